// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               controller. The master modport is the pipeline side (drives
//               hazard sources and the data-memory handshake). The slave
//               modport is the controller (drives stage stall/flush
//               controls, PC redirect select and watchdog pulse).
// Ports       : id_rs1/id_rs2        ID-stage source registers
//               ex_rd/ex_re_mem      EX-stage destination and load flag
//               ex_br_taken          EX-stage taken branch/jump
//               mem_except           MEM-stage exception valid
//               mem_csr_ret          MEM-stage xRET type (0 = none)
//               dmem_req/dmem_ack    MEM-stage data access handshake
//               *_stall / *_flush    per stage register hold / bubble
//               redirect_sel         0 seq, 1 branch, 2 trap vec, 3 epc
//               dmem_timeout         memory watchdog expiry pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] ex_rd;
   logic       ex_re_mem;
   logic       ex_br_taken;
   logic       mem_except;
   logic [1:0] mem_csr_ret;
   logic       dmem_req;
   logic       dmem_ack;
   logic       pc_stall;
   logic       ifid_stall;
   logic       idex_stall;
   logic       exmem_stall;
   logic       memwb_stall;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_flush;
   logic       memwb_flush;
   logic [1:0] redirect_sel;
   logic       dmem_timeout;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_re_mem, ex_br_taken,
      output mem_except, mem_csr_ret, dmem_req, dmem_ack,
      input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
      input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
      input  redirect_sel, dmem_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_re_mem, ex_br_taken,
      input  mem_except, mem_csr_ret, dmem_req, dmem_ack,
      output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
      output ifid_flush, idex_flush, exmem_flush, memwb_flush,
      output redirect_sel, dmem_timeout
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Five-stage pipeline hazard controller. A three-state FSM
//               (RUN, MEM_WAIT, TRAP) arbitrates traps/xRET, data-memory
//               waits, taken branches and load-use hazards, and produces
//               per-stage stall/flush controls plus the PC redirect select.
//               Outputs are combinational from state and inputs.
// Ports       : clk   - clock, posedge
//               rstn  - synchronous active-low reset
//               hz    - pipe_hazard_ctrl_if.slave (hazard sources in,
//                       stall/flush/redirect/timeout out)
// Parameters  : TIMEOUT_CYC - data-memory wait limit, 1..255 cycles
// Config      : DMEM_TIMEOUT_EN - when defined, adds the MEM_WAIT watchdog
//               that raises dmem_timeout and traps after TIMEOUT_CYC
//               MEM_WAIT cycles without ack.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  wire logic        clk,
   input  wire logic        rstn,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TRAP     = 2'd2
   } state_t;

   localparam logic [1:0] c_sel_seq  = 2'd0;
   localparam logic [1:0] c_sel_br   = 2'd1;
   localparam logic [1:0] c_sel_trap = 2'd2;
   localparam logic [1:0] c_sel_epc  = 2'd3;
   localparam logic [7:0] c_timeout_cyc = 8'(TIMEOUT_CYC);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] w_stall;   // {pc, ifid, idex, exmem}
   logic [3:0] w_flush;   // {ifid, idex, exmem, memwb}
   logic [1:0] w_sel;
   logic       w_timeout;
   logic       w_trap_ev;
   logic       w_mem_wait_ev;
   logic       w_load_use;

   assign w_trap_ev     = hz.mem_except | (hz.mem_csr_ret != 2'd0);
   assign w_mem_wait_ev = hz.dmem_req & ~hz.dmem_ack;
   // x0 is hardwired zero, so a load targeting it never creates a hazard.
   assign w_load_use    = hz.ex_re_mem && (hz.ex_rd != 5'd0) &&
                          ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

`ifdef DMEM_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       w_expired;

   // Counter holds the number of MEM_WAIT cycles seen, including the current one.
   assign w_expired = (r_wait_cnt >= c_timeout_cyc);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wait_cnt <= 8'd0;
      end else if (r_state == ST_RUN && w_next == ST_MEM_WAIT) begin
         r_wait_cnt <= 8'd1;
      end else if (w_next == ST_MEM_WAIT) begin
         if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
      end else begin
         r_wait_cnt <= 8'd0;
      end
   end
`else
   logic w_expired;
   logic w_unused_timeout;

   // No watchdog: the wait never expires and the limit has no effect.
   assign w_expired        = 1'b0;
   assign w_unused_timeout = ^c_timeout_cyc;
`endif

   always_comb begin
      w_next    = r_state;
      w_stall   = 4'b0000;
      w_flush   = 4'b0000;
      w_sel     = c_sel_seq;
      w_timeout = 1'b0;
      if (!rstn) begin
         // Every stage register is bubbled while reset is held.
         w_flush = 4'b1111;
         w_next  = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_trap_ev) begin
                  w_flush = 4'b1110;
                  w_sel   = hz.mem_except ? c_sel_trap : c_sel_epc;
                  w_next  = ST_TRAP;
               end else if (w_mem_wait_ev) begin
                  w_stall = 4'b1111;
                  w_flush = 4'b0001;
                  w_next  = ST_MEM_WAIT;
               end else if (hz.ex_br_taken) begin
                  w_flush = 4'b1100;
                  w_sel   = c_sel_br;
               end else if (w_load_use) begin
                  // pc/ifid hold, idex gets a bubble.
                  w_stall = 4'b1100;
                  w_flush = 4'b0100;
               end
            end
            ST_MEM_WAIT: begin
               if (hz.dmem_ack) begin
                  w_next = ST_RUN;
               end else if (w_expired) begin
                  w_timeout = 1'b1;
                  w_flush   = 4'b1110;
                  w_sel     = c_sel_trap;
                  w_next    = ST_TRAP;
               end else begin
                  w_stall = 4'b1111;
                  w_flush = 4'b0001;
               end
            end
            ST_TRAP: begin
               // Discard the wrong-path fetch made while redirecting.
               w_flush = 4'b1000;
               w_next  = ST_RUN;
            end
            default: begin
               w_flush = 4'b1111;
               w_next  = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_next;
   end

   assign hz.pc_stall     = w_stall[3];
   assign hz.ifid_stall   = w_stall[2] & ~w_flush[3];
   assign hz.idex_stall   = w_stall[1] & ~w_flush[2];
   assign hz.exmem_stall  = w_stall[0] & ~w_flush[1];
   assign hz.memwb_stall  = 1'b0;
   assign hz.ifid_flush   = w_flush[3];
   assign hz.idex_flush   = w_flush[2];
   assign hz.exmem_flush  = w_flush[1];
   assign hz.memwb_flush  = w_flush[0];
   assign hz.redirect_sel = w_sel;
   assign hz.dmem_timeout = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl. Each step
//               drives inputs just after posedge and compares the packed
//               control outputs at the following negedge against a
//               hand-computed vector {stall[5], flush[4], sel[2], timeout}.
//               The DUT is built with TIMEOUT_CYC = 4; the watchdog section
//               follows DMEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rstn;
   int   n_tests = 0;
   int   n_fail  = 0;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .hz   (hz)
   );

   always #5 clk = ~clk;

   // stall order {pc, ifid, idex, exmem, memwb}; flush order {ifid, idex, exmem, memwb}
   function automatic logic [11:0] o(input logic [4:0] s, input logic [3:0] f,
                                     input logic [1:0] r, input logic t);
      return {s, f, r, t};
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic re, input logic br,
                        input logic exc, input logic [1:0] ret,
                        input logic req, input logic ack);
      hz.id_rs1 = rs1;  hz.id_rs2 = rs2;  hz.ex_rd = rd;
      hz.ex_re_mem = re; hz.ex_br_taken = br;
      hz.mem_except = exc; hz.mem_csr_ret = ret;
      hz.dmem_req = req; hz.dmem_ack = ack;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   // Compare at negedge, then advance to just after the next posedge.
   task automatic chk(input string tag, input logic [11:0] exp);
      logic [11:0] obs;
      @(negedge clk);
      obs = {hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
             hz.memwb_stall, hz.ifid_flush, hz.idex_flush, hz.exmem_flush,
             hz.memwb_flush, hz.redirect_sel, hz.dmem_timeout};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      // Reset must override arbitrary hazard inputs.
      drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
      chk("reset_outputs", o(5'b00000, 4'b1111, 2'd0, 1'b0));

      rstn = 1'b1; idle();
      chk("run_idle", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Load-use through rs2, then the load has moved on.
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("load_use_rs2", o(5'b11000, 4'b0100, 2'd0, 1'b0));
      idle();
      chk("load_use_one_cycle", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("load_x0_no_stall", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      drive(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("load_use_rs1", o(5'b11000, 4'b0100, 2'd0, 1'b0));
      drive(5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("non_load_no_stall", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Branch beats load-use.
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("branch_over_load_use", o(5'b00000, 4'b1100, 2'd1, 1'b0));

      // Memory wait: three stall cycles, release on ack.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("mem_wait_enter", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      chk("mem_wait_ignores_events", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("mem_wait_3rd", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
      chk("mem_wait_ack", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("run_after_ack", o(5'b00000, 4'b1100, 2'd1, 1'b0));

      // Request acked in the same cycle: no wait.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
      chk("req_ack_same_cycle", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("still_run", o(5'b00000, 4'b1100, 2'd1, 1'b0));

      // Exception wins over xRET and memory request.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      chk("trap_exception", o(5'b00000, 4'b1110, 2'd2, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("trap_state", o(5'b00000, 4'b1000, 2'd0, 1'b0));
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      chk("xret", o(5'b00000, 4'b1110, 2'd3, 1'b0));
      idle();
      chk("xret_trap_state", o(5'b00000, 4'b1000, 2'd0, 1'b0));
      chk("trap_returns_run", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Reset mid-MEM_WAIT.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("rst_wait_enter", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      chk("rst_wait_hold", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      rstn = 1'b0;
      chk("rst_in_wait", o(5'b00000, 4'b1111, 2'd0, 1'b0));
      rstn = 1'b1; idle();
      chk("run_after_wait_rst", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Reset mid-TRAP.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      chk("rst_trap_enter", o(5'b00000, 4'b1110, 2'd2, 1'b0));
      rstn = 1'b0; idle();
      chk("rst_in_trap", o(5'b00000, 4'b1111, 2'd0, 1'b0));
      rstn = 1'b1;
      chk("run_after_trap_rst", o(5'b00000, 4'b0000, 2'd0, 1'b0));

`ifdef DMEM_TIMEOUT_EN
      // Expiry on the 4th MEM_WAIT cycle, then TRAP, then RUN.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("to_enter", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      for (int i = 1; i <= 3; i++) chk("to_wait", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      chk("to_pulse", o(5'b00000, 4'b1110, 2'd2, 1'b1));
      idle();
      chk("to_trap", o(5'b00000, 4'b1000, 2'd0, 1'b0));
      chk("to_run", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Ack in the expiry cycle wins.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("to_ack_enter", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      for (int i = 1; i <= 3; i++) chk("to_ack_wait", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      hz.dmem_ack = 1'b1;
      chk("to_ack_wins", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      idle();
      chk("to_ack_run", o(5'b00000, 4'b0000, 2'd0, 1'b0));

      // Reset during wait: no pulse afterwards.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("to_rst_enter", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      chk("to_rst_wait", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      rstn = 1'b0;
      chk("to_rst_held", o(5'b00000, 4'b1111, 2'd0, 1'b0));
      rstn = 1'b1; idle();
      for (int i = 0; i < 5; i++) chk("to_rst_no_pulse", o(5'b00000, 4'b0000, 2'd0, 1'b0));
`else
      // No watchdog: wait persists well past the limit.
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) chk("no_to_wait", o(5'b11110, 4'b0001, 2'd0, 1'b0));
      hz.dmem_ack = 1'b1;
      chk("no_to_ack", o(5'b00000, 4'b0000, 2'd0, 1'b0));
      idle();
      chk("no_to_run", o(5'b00000, 4'b0000, 2'd0, 1'b0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed no completion required completion");
      $fatal(1, "time limit");
   end
endmodule
`default_nettype wire
